// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush control bundle between the pipeline and its controller.
// Counter signals exist only when PIPE_PERF_EN is defined.
interface pipe_ctrl_if;
  logic hazard, branch_taken, mem_wait, halt_req, resume;
  logic pc_en, ifid_en, idex_en, pipe_en, ifid_flush, idex_flush, halted, stall_err;
`ifdef PIPE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  modport master(output hazard, branch_taken, mem_wait, halt_req, resume,
                 input pc_en, ifid_en, idex_en, pipe_en, ifid_flush, idex_flush, halted, stall_err,
                 input stall_cnt, flush_cnt);
  modport slave(input hazard, branch_taken, mem_wait, halt_req, resume,
                output pc_en, ifid_en, idex_en, pipe_en, ifid_flush, idex_flush, halted, stall_err,
                output stall_cnt, flush_cnt);
`else
  modport master(output hazard, branch_taken, mem_wait, halt_req, resume,
                 input pc_en, ifid_en, idex_en, pipe_en, ifid_flush, idex_flush, halted, stall_err);
  modport slave(input hazard, branch_taken, mem_wait, halt_req, resume,
                output pc_en, ifid_en, idex_en, pipe_en, ifid_flush, idex_flush, halted, stall_err);
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Mealy pipeline stall/flush/halt controller with stall watchdog.
// Define PIPE_PERF_EN to add saturating stall/flush performance counters.
module pipe_ctrl (
  input logic clk,
  input logic rst_n,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  state_t state, state_nx;
  logic [1:0] dcnt, dcnt_nx, wd, wd_nx;
  logic err_q, err_nx;
  logic pc_en, ifid_en, idex_en, pipe_en, ifid_flush, idex_flush, halted;
  always_comb begin
    state_nx = state;
    dcnt_nx = dcnt;
    wd_nx = wd;
    err_nx = err_q;
    pc_en = 1'b1;
    ifid_en = 1'b1;
    idex_en = 1'b1;
    pipe_en = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted = 1'b0;
    case (state)
      RUN:
        if (bus.mem_wait) begin
          {pc_en, ifid_en, idex_en, pipe_en} = 4'b0000;
        end else if (bus.branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          wd_nx = 2'd0;
        end else if (bus.hazard) begin
          pc_en = 1'b0;
          ifid_en = 1'b0;
          idex_flush = 1'b1;
          wd_nx = (wd == 2'd3) ? wd : wd + 2'd1;
          err_nx = err_q | (wd >= 2'd2);
        end else begin
          wd_nx = 2'd0;
          state_nx = bus.halt_req ? DRAIN : RUN;
          dcnt_nx = bus.halt_req ? 2'd3 : dcnt;
        end
      DRAIN: begin
        pc_en = 1'b0;
        ifid_en = 1'b0;
        idex_flush = 1'b1;
        pipe_en = ~bus.mem_wait;
        dcnt_nx = bus.mem_wait ? dcnt : dcnt - 2'd1;
        state_nx = (!bus.mem_wait && dcnt == 2'd1) ? HALT : DRAIN;
      end
      HALT: begin
        {pc_en, ifid_en, idex_en, pipe_en} = 4'b0000;
        halted = 1'b1;
        state_nx = bus.resume ? RUN : HALT;
      end
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      dcnt <= 2'd0;
      wd <= 2'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      dcnt <= dcnt_nx;
      wd <= wd_nx;
      err_q <= err_nx;
    end
  // reset forces every control output low, independent of state and inputs
  assign bus.pc_en = rst_n & pc_en;
  assign bus.ifid_en = rst_n & ifid_en;
  assign bus.idex_en = rst_n & idex_en;
  assign bus.pipe_en = rst_n & pipe_en;
  assign bus.ifid_flush = rst_n & ifid_flush;
  assign bus.idex_flush = rst_n & idex_flush;
  assign bus.halted = rst_n & halted;
  assign bus.stall_err = err_q;
`ifdef PIPE_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic stall_inc, flush_inc;
  assign stall_inc = (state == RUN) && !pc_en;
  assign flush_inc = (state == RUN) && !bus.mem_wait && bus.branch_taken;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
      flush_q <= (flush_inc && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
    end
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl; counter checks run only with PIPE_PERF_EN.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  localparam logic [6:0] RUNO = 7'b1111000;
  localparam logic [6:0] FLSH = 7'b1111110;
  localparam logic [6:0] STL = 7'b0011010;
  localparam logic [6:0] DRN = 7'b0011010;
  localparam logic [6:0] DRW = 7'b0010010;
  localparam logic [6:0] HLT = 7'b0000001;
  localparam logic [6:0] ZERO = 7'b0000000;
  always #5 clk = ~clk;
  pipe_ctrl_if bus();
  pipe_ctrl dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [6:0] outs;
  assign outs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.pipe_en, bus.ifid_flush, bus.idex_flush, bus.halted};
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic h, input logic b, input logic m, input logic q, input logic r);
    bus.hazard = h;
    bus.branch_taken = b;
    bus.mem_wait = m;
    bus.halt_req = q;
    bus.resume = r;
    #1;
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drv(1, 1, 0, 1, 1);
    chk("rst_outs", 16'(outs), 16'(ZERO));
    chk("rst_err", 16'(bus.stall_err), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(0, 0, 0, 0, 0);
    chk("run_idle", 16'(outs), 16'(RUNO));
    nxt;
    drv(1, 0, 0, 0, 0);
    chk("haz1", 16'(outs), 16'(STL));
    nxt;
    chk("haz2", 16'(outs), 16'(STL));
    nxt;
    drv(0, 0, 0, 0, 0);
    chk("haz_end", 16'(outs), 16'(RUNO));
    chk("haz_err", 16'(bus.stall_err), 16'd0);
`ifdef PIPE_PERF_EN
    chk("stall_cnt2", bus.stall_cnt, 16'd2);
`endif
    nxt;
    drv(1, 1, 0, 1, 0);
    chk("br_haz", 16'(outs), 16'(FLSH));
    nxt;
`ifdef PIPE_PERF_EN
    chk("flush_cnt1", bus.flush_cnt, 16'd1);
    chk("stall_keep", bus.stall_cnt, 16'd2);
`endif
    drv(0, 1, 1, 0, 0);
    chk("mw_br", 16'(outs), 16'(ZERO));
    nxt;
`ifdef PIPE_PERF_EN
    chk("flush_hold", bus.flush_cnt, 16'd1);
    chk("stall_mw", bus.stall_cnt, 16'd3);
`endif
    drv(0, 1, 0, 0, 0);
    chk("br_after_mw", 16'(outs), 16'(FLSH));
    nxt;
`ifdef PIPE_PERF_EN
    chk("flush_cnt2", bus.flush_cnt, 16'd2);
`endif
    drv(1, 0, 0, 0, 0);
    chk("wd_s1", 16'(outs), 16'(STL));
    nxt;
    drv(1, 0, 1, 0, 0);
    chk("wd_mw", 16'(outs), 16'(ZERO));
    nxt;
    drv(1, 0, 0, 0, 0);
    chk("wd_s2", 16'(outs), 16'(STL));
    nxt;
    chk("wd_err0", 16'(bus.stall_err), 16'd0);
    chk("wd_s3", 16'(outs), 16'(STL));
    nxt;
    chk("wd_err1", 16'(bus.stall_err), 16'd1);
    drv(0, 0, 0, 0, 0);
    nxt;
    chk("wd_sticky", 16'(bus.stall_err), 16'd1);
`ifdef PIPE_PERF_EN
    chk("stall_cnt7", bus.stall_cnt, 16'd7);
`endif
    drv(0, 0, 0, 1, 0);
    chk("halt_req", 16'(outs), 16'(RUNO));
    nxt;
    drv(1, 1, 0, 1, 0);
    chk("drain1", 16'(outs), 16'(DRN));
    nxt;
    drv(0, 0, 1, 0, 1);
    chk("drain_w1", 16'(outs), 16'(DRW));
    nxt;
    chk("drain_w2", 16'(outs), 16'(DRW));
    nxt;
    drv(0, 0, 0, 0, 0);
    chk("drain4", 16'(outs), 16'(DRN));
    nxt;
    chk("drain5", 16'(outs), 16'(DRN));
    nxt;
    chk("halt1", 16'(outs), 16'(HLT));
    nxt;
    chk("halt2", 16'(outs), 16'(HLT));
`ifdef PIPE_PERF_EN
    chk("stall_drain", bus.stall_cnt, 16'd7);
`endif
    drv(0, 0, 0, 0, 1);
    chk("halt_res", 16'(outs), 16'(HLT));
    nxt;
    drv(0, 0, 0, 0, 0);
    chk("resumed", 16'(outs), 16'(RUNO));
`ifdef PIPE_PERF_EN
    force dut.stall_q = 16'hFFFF;
    #1 release dut.stall_q;
    drv(1, 0, 0, 0, 0);
    nxt;
    chk("stall_sat", bus.stall_cnt, 16'hFFFF);
    drv(0, 0, 0, 0, 0);
    nxt;
`endif
    drv(0, 0, 0, 1, 0);
    nxt;
    drv(0, 0, 0, 0, 0);
    chk("pre_rst_drain", 16'(outs), 16'(DRN));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 16'(outs), 16'(ZERO));
    chk("rst_mid_err", 16'(bus.stall_err), 16'd0);
`ifdef PIPE_PERF_EN
    chk("rst_stall", bus.stall_cnt, 16'd0);
    chk("rst_flush", bus.flush_cnt, 16'd0);
`endif
    nxt;
    rst_n = 1'b1;
    #1;
    chk("post_rst_run", 16'(outs), 16'(RUNO));
    nxt;
    chk("post_rst_edge", 16'(outs), 16'(RUNO));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 hazard  in  1  load/use stall request from the ID-stage hazard detector.
REQ-004 branch_taken  in  1  a branch or jump resolved taken in EX this cycle.
REQ-005 mem_wait  in  1  data memory not ready; the whole pipeline must freeze.
REQ-006 halt_req  in  1  a halting instruction (syscall) is decoded in ID.
REQ-007 resume  in  1  single-cycle pulse that leaves HALT.
REQ-008 pc_en, ifid_en, idex_en, pipe_en  out  1 each  enables for PC, IF/ID, ID/EX, and EX/MEM plus MEM/WB.
REQ-009 ifid_flush, idex_flush  out  1 each  insert a bubble into IF/ID or ID/EX.
REQ-010 halted  out  1  high while in HALT.
REQ-011 stall_err  out  1  sticky flag for a stall-length violation.
REQ-012 stall_cnt, flush_cnt  out  16 each  performance counters, present only with PIPE_PERF_EN.

Function
REQ-013 States RUN, DRAIN, HALT; outputs are combinational from registered state and current inputs (Mealy).
REQ-014 Default (RUN, no event): all enables 1, both flushes 0, halted 0.
REQ-015 Priority in RUN is mem_wait > branch_taken > hazard > halt_req.
REQ-016 RUN with mem_wait=1: all enables 0, both flushes 0, no state change, no counter updates except REQ-024.
REQ-017 RUN with branch_taken=1 and mem_wait=0: all enables 1, ifid_flush=1, idex_flush=1; the hazard and halt_req inputs are ignored (wrong path).
REQ-018 RUN with hazard=1 and no higher event: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, pipe_en=1; halt_req is ignored.
REQ-019 RUN with halt_req=1 and no higher event: the outputs equal REQ-014 for that cycle (the syscall advances to EX); next state DRAIN; drain counter loaded with 3.
REQ-020 DRAIN: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, pipe_en=~mem_wait; branch_taken, hazard and halt_req are ignored.
REQ-021 DRAIN: the counter decrements only on mem_wait=0 cycles; the transition to HALT occurs on the edge where the counter is 1 and mem_wait=0, i.e. after exactly 3 non-wait cycles.
REQ-022 HALT: all enables and flushes 0, halted=1; resume=1 gives RUN at the next edge; resume is ignored in RUN and DRAIN.
REQ-023 Watchdog: a 2-bit saturating count of consecutive REQ-018 stall cycles.
  - Cleared by any RUN cycle with mem_wait=0 that is not a REQ-018 stall.
  - Held on mem_wait cycles.
  - stall_err is set at the edge on which the count would reach 3.
  - stall_err stays set until reset.
REQ-024 stall_cnt increments on each cycle in which pc_en=0 while in RUN (causes: mem_wait or hazard).
REQ-025 flush_cnt increments on each REQ-017 cycle.
REQ-026 Both counters saturate at 16'hFFFF and never wrap.

Reset
REQ-027 While rst_n=0: state=RUN, drain counter 0, watchdog 0, stall_err 0, counters 0.
REQ-028 While rst_n=0: all enables 0, both flushes 0, halted 0, regardless of the other inputs.
REQ-029 Reset asserted in DRAIN or HALT returns to RUN immediately; the first edge after deassertion behaves as RUN.

Configuration
REQ-030 Macro PIPE_PERF_EN defined: stall_cnt, flush_cnt and their logic exist per REQ-024 to REQ-026.
REQ-031 PIPE_PERF_EN undefined: those ports and their logic are absent; all other behaviour is identical.

Verification
REQ-032 RUN, hazard=1 for 2 cycles then 0 -> pc_en=0, ifid_en=0, idex_flush=1 for 2 cycles; stall_err=0; stall_cnt=2.
REQ-033 hazard=1 and branch_taken=1 in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1; stall_cnt unchanged.
REQ-034 halt_req=1 then mem_wait=1 in the 2nd DRAIN cycle for 2 cycles -> halted rises after 5 DRAIN cycles; pipe_en=0 during the wait; resume -> RUN with enables 1.
REQ-035 hazard=1 held for 3 stall cycles with 1 mem_wait cycle in between -> stall_err=1 after the 3rd stall and stays 1 until rst_n=0.
REQ-036 mem_wait=1 with branch_taken=1 -> all enables 0, flushes 0; flush is taken the first cycle mem_wait=0.
REQ-037 Force stall_cnt to 16'hFFFF, apply a hazard stall -> stays 16'hFFFF; rst_n=0 mid-DRAIN -> state RUN, halted=0, counters 0.
